// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute boundary: control-bundle bit
// positions, the bubble control pattern and the per-edge stage action.
package pipe_pkg;

  localparam int CTRL_W   = 8;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;

  // Bit positions inside the 8-bit control bundle
  // {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp[1:0]}
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  // A bubble carries no side effects: no write-back, no memory access,
  // no branch, ALUOp 00.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

  // What the register bank does on the coming edge (reset is handled
  // separately because it overrides everything).
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_HOLD   = 2'd3
  } stage_action_e;

endpackage

// File: rtl/id_ex_pipeline_reg_hazard.sv
// Load-use hazard detection for the instruction sitting in decode against
// the instruction held in ID/EX. Purely combinational.
module hazard_detect_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [1:0]            id_uses,
  output logic                  lu,
  output logic                  pc_write,
  output logic                  if_id_write
);

  logic rs1_match;
  logic rs2_match;

  // A load in EX whose destination is read by decode forces a one-cycle stall;
  // while reset is asserted the held instruction is treated as invalid.
  always_comb begin
    rs1_match   = id_uses[0] && (ex_rd == id_rs1);
    rs2_match   = id_uses[1] && (ex_rd == id_rs2);
    lu          = reset && id_valid && ex_valid && ex_mem_read
                  && (ex_rd != '0) && (rs1_match || rs2_match);
    pc_write    = !hold && (flush || !lu);
    if_id_write = pc_write;
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded operands and control each cycle,
// inserts bubbles for load-use hazards and branch flushes, honours downstream
// hold, and keeps saturating bubble/flush event counters.
module id_ex_pipeline_reg
  import pipe_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [XLEN-1:0]       id_rd1,
  input  logic [XLEN-1:0]       id_rd2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [1:0]            id_uses,
  input  logic [FUNCT3_W-1:0]   id_funct3,
  input  logic [FUNCT7_W-1:0]   id_funct7,
  input  logic [CTRL_W-1:0]     id_ctrl,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_rd1,
  output logic [XLEN-1:0]       ex_rd2,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [FUNCT3_W-1:0]   ex_funct3,
  output logic [FUNCT7_W-1:0]   ex_funct7,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic          lu;
  stage_action_e action;

  hazard_detect_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .reset       (reset),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses     (id_uses),
    .lu          (lu),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // Pick the edge action by priority: hold, then flush, then load-use, else load.
  always_comb begin
    action = ACT_LOAD;
    if (hold) begin
      action = ACT_HOLD;
    end else if (flush) begin
      action = ACT_FLUSH;
    end else if (lu) begin
      action = ACT_BUBBLE;
    end
  end

  // Register bank: reset clears, hold freezes, flush/lu inject a bubble, else capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_imm    <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
      ex_ctrl   <= CTRL_BUBBLE;
    end else begin
      unique case (action)
        ACT_HOLD: begin
          ex_valid  <= ex_valid;
          ex_pc     <= ex_pc;
          ex_imm    <= ex_imm;
          ex_rd1    <= ex_rd1;
          ex_rd2    <= ex_rd2;
          ex_rs1    <= ex_rs1;
          ex_rs2    <= ex_rs2;
          ex_rd     <= ex_rd;
          ex_funct3 <= ex_funct3;
          ex_funct7 <= ex_funct7;
          ex_ctrl   <= ex_ctrl;
        end
        ACT_FLUSH, ACT_BUBBLE: begin
          ex_valid  <= 1'b0;
          ex_pc     <= '0;
          ex_imm    <= '0;
          ex_rd1    <= '0;
          ex_rd2    <= '0;
          ex_rs1    <= '0;
          ex_rs2    <= '0;
          ex_rd     <= '0;
          ex_funct3 <= '0;
          ex_funct7 <= '0;
          ex_ctrl   <= CTRL_BUBBLE;
        end
        default: begin
          ex_valid  <= id_valid;
          ex_pc     <= id_pc;
          ex_imm    <= id_imm;
          ex_rd1    <= id_rd1;
          ex_rd2    <= id_rd2;
          ex_rs1    <= id_rs1;
          ex_rs2    <= id_rs2;
          ex_rd     <= id_rd;
          ex_funct3 <= id_funct3;
          ex_funct7 <= id_funct7;
          ex_ctrl   <= id_ctrl;
        end
      endcase
    end
  end

  // Saturating event counters: one count per applied flush or load-use bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (action == ACT_FLUSH) begin
      if (flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end else if (action == ACT_BUBBLE) begin
      if (bubble_cnt != CNT_MAX) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a driver applies directed and
// random decode traffic and queues the expected view; a monitor compares.
module tb_id_ex_pipeline_reg;

  localparam int XLEN    = 64;
  localparam int RAW     = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            reset;
    logic            hold;
    logic            flush;
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [1:0]      uses;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [7:0]      ctrl;
  } stim_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [7:0]      ctrl;
    logic            pw;
    int unsigned     bcnt;
    int unsigned     fcnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset, hold, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_imm, id_rd1, id_rd2;
  logic [RAW-1:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]      id_uses;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [7:0]      id_ctrl;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
  logic [RAW-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [7:0]      ex_ctrl;
  logic            pc_write, if_id_write;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  exp_t q[$];
  exp_t model;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses(id_uses), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_ctrl(ex_ctrl), .pc_write(pc_write), .if_id_write(if_id_write),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  // Does the decode instruction read the destination of a load now in EX?
  function automatic bit model_lu(exp_t c, stim_t s);
    bit reads_it;
    reads_it = (s.uses[0] && c.rd == s.rs1) || (s.uses[1] && c.rd == s.rs2);
    return s.reset && s.valid && c.valid && c.ctrl[5] && c.rd != 0 && reads_it;
  endfunction

  // What EX looks like after the coming edge, from the stage's rules.
  function automatic exp_t model_next(exp_t c, stim_t s);
    exp_t n;
    n = c;
    if (!s.reset) begin
      n = '0;
    end else if (s.hold) begin
      n = c;
    end else if (s.flush || model_lu(c, s)) begin
      n = '0;
      n.bcnt = c.bcnt;
      n.fcnt = c.fcnt;
      if (s.flush) n.fcnt = (c.fcnt < CNT_MAX) ? c.fcnt + 1 : CNT_MAX;
      else         n.bcnt = (c.bcnt < CNT_MAX) ? c.bcnt + 1 : CNT_MAX;
    end else begin
      n.valid = s.valid; n.pc = s.pc; n.imm = s.imm;
      n.rd1 = s.rd1; n.rd2 = s.rd2; n.rs1 = s.rs1; n.rs2 = s.rs2;
      n.rd = s.rd; n.f3 = s.f3; n.f7 = s.f7; n.ctrl = s.ctrl;
    end
    n.pw = 1'b0;
    return n;
  endfunction

  function automatic stim_t base_stim();
    stim_t s;
    s = '0;
    s.reset = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.reset = ($urandom_range(0, 99) >= 3);
    s.hold  = ($urandom_range(0, 99) < 15);
    s.flush = ($urandom_range(0, 99) < 10);
    s.valid = ($urandom_range(0, 9) < 8);
    s.pc    = {$urandom, $urandom};
    s.imm   = {$urandom, $urandom};
    s.rd1   = {$urandom, $urandom};
    s.rd2   = {$urandom, $urandom};
    s.rs1   = RAW'($urandom_range(0, 3));
    s.rs2   = RAW'($urandom_range(0, 3));
    s.rd    = RAW'($urandom_range(0, 3));
    s.uses  = 2'($urandom_range(0, 3));
    s.f3    = 3'($urandom);
    s.f7    = 7'($urandom);
    s.ctrl  = 8'($urandom);
    s.ctrl[5] = $urandom_range(0, 1) == 1;
    return s;
  endfunction

  function automatic stim_t instr(logic [RAW-1:0] rd, logic [RAW-1:0] rs1,
                                  logic [RAW-1:0] rs2, logic [1:0] uses,
                                  logic [7:0] ctrl);
    stim_t s;
    s = base_stim();
    s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.uses = uses; s.ctrl = ctrl;
    s.pc = XLEN'($urandom); s.rd1 = XLEN'($urandom); s.rd2 = XLEN'($urandom);
    s.f3 = 3'($urandom); s.f7 = 7'($urandom);
    return s;
  endfunction

  // Drive one cycle of decode inputs and queue what the monitor should see.
  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset = s.reset; hold = s.hold; flush = s.flush; id_valid = s.valid;
    id_pc = s.pc; id_imm = s.imm; id_rd1 = s.rd1; id_rd2 = s.rd2;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_uses = s.uses;
    id_funct3 = s.f3; id_funct7 = s.f7; id_ctrl = s.ctrl;
    e = model;
    e.pw = !s.hold && (s.flush || !model_lu(model, s));
    q.push_back(e);
    model = model_next(model, s);
  endtask

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents the current ID/EX view.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check_output("ex_valid", 64'(ex_valid), 64'(e.valid));
        check_output("ex_pc", ex_pc, e.pc);
        check_output("ex_imm", ex_imm, e.imm);
        check_output("ex_rd1", ex_rd1, e.rd1);
        check_output("ex_rd2", ex_rd2, e.rd2);
        check_output("ex_rs1", 64'(ex_rs1), 64'(e.rs1));
        check_output("ex_rs2", 64'(ex_rs2), 64'(e.rs2));
        check_output("ex_rd", 64'(ex_rd), 64'(e.rd));
        check_output("ex_funct3", 64'(ex_funct3), 64'(e.f3));
        check_output("ex_funct7", 64'(ex_funct7), 64'(e.f7));
        check_output("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
        check_output("pc_write", 64'(pc_write), 64'(e.pw));
        check_output("if_id_write", 64'(if_id_write), 64'(e.pw));
        check_output("bubble_cnt", 64'(bubble_cnt), 64'(e.bcnt));
        check_output("flush_cnt", 64'(flush_cnt), 64'(e.fcnt));
      end
    end
  end

  // Driver: directed scenarios first, then random traffic.
  initial begin
    stim_t s;
    model = '0;
    s = rand_stim();
    reset = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = s.valid;
    id_pc = s.pc; id_imm = s.imm; id_rd1 = s.rd1; id_rd2 = s.rd2;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_uses = s.uses;
    id_funct3 = s.f3; id_funct7 = s.f7; id_ctrl = s.ctrl;

    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.reset = 1'b0; s.hold = 1'b0;
      apply_stimulus(s);
    end

    s = base_stim(); s.valid = 1'b1; s.pc = 64'h100; s.imm = 64'h8; s.ctrl = 8'hA2;
    apply_stimulus(s);
    apply_stimulus(base_stim());

    apply_stimulus(instr(5'd5, 5'd2, 5'd3, 2'b00, 8'hE4));
    apply_stimulus(instr(5'd6, 5'd5, 5'd1, 2'b01, 8'h82));
    apply_stimulus(instr(5'd6, 5'd5, 5'd1, 2'b01, 8'h82));
    apply_stimulus(base_stim());

    apply_stimulus(instr(5'd0, 5'd2, 5'd3, 2'b00, 8'hE4));
    apply_stimulus(instr(5'd6, 5'd0, 5'd0, 2'b11, 8'h82));
    apply_stimulus(instr(5'd5, 5'd2, 5'd3, 2'b00, 8'hE4));
    apply_stimulus(instr(5'd7, 5'd1, 5'd5, 2'b01, 8'h82));
    apply_stimulus(base_stim());

    apply_stimulus(instr(5'd5, 5'd2, 5'd3, 2'b00, 8'hE4));
    s = instr(5'd6, 5'd5, 5'd5, 2'b11, 8'h82); s.flush = 1'b1;
    apply_stimulus(s);
    apply_stimulus(base_stim());

    apply_stimulus(instr(5'd9, 5'd1, 5'd2, 2'b11, 8'hA6));
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.reset = 1'b1; s.hold = 1'b1; s.flush = 1'b1;
      apply_stimulus(s);
    end
    s = rand_stim(); s.reset = 1'b1; s.hold = 1'b0; s.flush = 1'b1;
    apply_stimulus(s);
    apply_stimulus(base_stim());

    s = base_stim(); s.reset = 1'b0;
    apply_stimulus(s);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(instr(5'd5, 5'd2, 5'd3, 2'b00, 8'hE4));
      apply_stimulus(instr(5'd6, 5'd5, 5'd1, 2'b01, 8'h82));
      apply_stimulus(instr(5'd6, 5'd5, 5'd1, 2'b01, 8'h82));
    end

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(rand_stim());
    end

    @(negedge clk);
    #1;
    check_output("queue_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
